// File: rtl/conv_frame_arbiter_pkg.sv
// conv_frame_arbiter_pkg: shared state encoding, tag width and sizing helpers for the frame arbiter
package conv_frame_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
    localparam int TAG_W = 1;
    function automatic int transfers_per_pixel(int in_channel, int width, int word_width);
        return in_channel / (width / word_width);
    endfunction
    function automatic int tpi(int in_height, int in_width, int in_channel, int width, int word_width);
        return transfers_per_pixel(in_channel, width, word_width) * in_height * in_width;
    endfunction
    function automatic int cnt_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_frame_arbiter_tag_fifo.sv
// conv_frame_arbiter_tag_fifo: in-order sink tags for images granted but not yet fully drained
module conv_frame_arbiter_tag_fifo
    import conv_frame_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             i_aclk,
    input  logic             i_areset,
    input  logic             push,
    input  logic             pop,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge i_aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
    // Extra pointer bit separates full from empty when the indices coincide
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assert property (@(posedge i_aclk) disable iff (i_areset) !(push && full) && !(pop && empty));
endmodule

// File: rtl/conv_frame_arbiter.sv
// conv_frame_arbiter: shares one conv core between two image sources, steering results back by tag
module conv_frame_arbiter
    import conv_frame_arbiter_pkg::*;
#(
    parameter int IN_HEIGHT  = 4,
    parameter int IN_WIDTH   = 4,
    parameter int IN_CHANNEL = 2,
    parameter int WIDTH      = 8,
    parameter int WORD_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_BEATS  = 16,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                 i_aclk,
    input  logic                 i_areset,
    input  logic                 i_s0_tvalid,
    output logic                 o_s0_tready,
    input  logic [WIDTH-1:0]     i_s0_tdata,
    input  logic                 i_s1_tvalid,
    output logic                 o_s1_tready,
    input  logic [WIDTH-1:0]     i_s1_tdata,
    output logic                 o_core_tvalid,
    input  logic                 i_core_tready,
    output logic [WIDTH-1:0]     o_core_tdata,
    input  logic                 i_res_tvalid,
    output logic                 o_res_tready,
    input  logic [OUT_WIDTH-1:0] i_res_tdata,
    output logic                 o_m0_tvalid,
    input  logic                 i_m0_tready,
    output logic [OUT_WIDTH-1:0] o_m0_tdata,
    output logic                 o_m1_tvalid,
    input  logic                 i_m1_tready,
    output logic [OUT_WIDTH-1:0] o_m1_tdata,
    output logic [1:0]           o_grant
);
    localparam int TPI = tpi(IN_HEIGHT, IN_WIDTH, IN_CHANNEL, WIDTH, WORD_WIDTH);
    localparam int ICW = cnt_w(TPI);
    localparam int OCW = cnt_w(OUT_BEATS);
    localparam logic [ICW-1:0] IN_LAST  = ICW'(TPI - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);
    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             pick;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             in_hs;
    logic             res_hs;
    logic [TAG_W-1:0] head;
    logic [ICW-1:0]   in_cnt;
    logic [OCW-1:0]   out_cnt;
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state   <= IDLE;
            last    <= 1'b1;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (push) last <= pick;
            if (in_hs) in_cnt <= in_cnt == IN_LAST ? '0 : in_cnt + 1'b1;
            if (res_hs) out_cnt <= pop ? '0 : out_cnt + 1'b1;
        end
    end
    // Grant is decided in IDLE only; the tag push and the state change share the same edge
    always_comb begin
        pick          = (i_s0_tvalid && i_s1_tvalid) ? !last : i_s1_tvalid;
        push          = state == IDLE && !full && (i_s0_tvalid || i_s1_tvalid);
        o_core_tvalid = state == GNT0 ? i_s0_tvalid : state == GNT1 ? i_s1_tvalid : 1'b0;
        o_core_tdata  = state == GNT1 ? i_s1_tdata : i_s0_tdata;
        o_s0_tready   = state == GNT0 && i_core_tready;
        o_s1_tready   = state == GNT1 && i_core_tready;
        o_grant       = {state == GNT1, state == GNT0};
        in_hs         = o_core_tvalid && i_core_tready;
        state_nxt     = state;
        if (push) state_nxt = pick ? GNT1 : GNT0;
        else if (in_hs && in_cnt == IN_LAST) state_nxt = IDLE;
    end
    always_comb begin
        o_m0_tvalid  = !empty && head == 1'b0 && i_res_tvalid;
        o_m1_tvalid  = !empty && head == 1'b1 && i_res_tvalid;
        o_res_tready = !empty && (head == 1'b1 ? i_m1_tready : i_m0_tready);
        o_m0_tdata   = i_res_tdata;
        o_m1_tdata   = i_res_tdata;
        res_hs       = i_res_tvalid && o_res_tready;
        pop          = res_hs && out_cnt == OUT_LAST;
    end
    conv_frame_arbiter_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .i_aclk   (i_aclk),
        .i_areset (i_areset),
        .push     (push),
        .pop      (pop),
        .din      (pick),
        .dout     (head),
        .full     (full),
        .empty    (empty)
    );
endmodule

// File: tb/tb_conv_frame_arbiter.sv
// tb_conv_frame_arbiter: randomized scoreboard bench for the two-source frame arbiter
module tb_conv_frame_arbiter;
    localparam int TPI = 32;
    localparam int OB  = 16;
    logic        i_aclk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_s0_tvalid = 1'b0, i_s1_tvalid = 1'b0;
    logic [7:0]  i_s0_tdata = '0, i_s1_tdata = '0;
    logic        o_s0_tready, o_s1_tready, o_core_tvalid;
    logic        i_core_tready = 1'b0;
    logic [7:0]  o_core_tdata;
    logic        i_res_tvalid = 1'b0, o_res_tready;
    logic [15:0] i_res_tdata = '0;
    logic        o_m0_tvalid, o_m1_tvalid;
    logic        i_m0_tready = 1'b0, i_m1_tready = 1'b0;
    logic [15:0] o_m0_tdata, o_m1_tdata;
    logic [1:0]  o_grant;

    conv_frame_arbiter dut (
        .i_aclk(i_aclk), .i_areset(i_areset),
        .i_s0_tvalid(i_s0_tvalid), .o_s0_tready(o_s0_tready), .i_s0_tdata(i_s0_tdata),
        .i_s1_tvalid(i_s1_tvalid), .o_s1_tready(o_s1_tready), .i_s1_tdata(i_s1_tdata),
        .o_core_tvalid(o_core_tvalid), .i_core_tready(i_core_tready), .o_core_tdata(o_core_tdata),
        .i_res_tvalid(i_res_tvalid), .o_res_tready(o_res_tready), .i_res_tdata(i_res_tdata),
        .o_m0_tvalid(o_m0_tvalid), .i_m0_tready(i_m0_tready), .o_m0_tdata(o_m0_tdata),
        .o_m1_tvalid(o_m1_tvalid), .i_m1_tready(i_m1_tready), .o_m1_tdata(o_m1_tdata),
        .o_grant(o_grant)
    );

    always #5 i_aclk = ~i_aclk;

    int checks = 0, passed = 0, cyc = 0;
    logic [7:0]  src0_q[$], src1_q[$], exp_core[$];
    logic [15:0] exp_m0[$], exp_m1[$];
    bit          order[$];
    bit          m_last = 1'b1;
    int src_idx0, src_idx1, img_done, in_beats, res_img, res_beat, res_cnt;
    int res_limit = 1000;
    int rise_cyc = 0, end_cyc = 0, pop_cyc = 0, last_len = 0, last_gap = 0, last_pop_gap = 0;
    int cmode = 1, m0mode = 1, m1mode = 1;
    bit src_gap = 0, res_gap = 0, res_pushed = 0, just_ended = 0;
    bit s0_hs = 0, s1_hs = 0, r_hs = 0;
    logic [1:0] prev_grant = 2'b00;

    always @(posedge i_aclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bad(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic flush();
        src0_q.delete(); src1_q.delete(); exp_core.delete(); order.delete();
        exp_m0.delete(); exp_m1.delete();
        src_idx0 = 0; src_idx1 = 0; img_done = 0; in_beats = 0;
        res_img = 0; res_beat = 0; res_cnt = 0; res_pushed = 0;
        m_last = 1'b1; just_ended = 0;
    endtask

    // Reference: whole images alternate between sources while both have work, s0 first after reset
    task automatic plan(input int n0, input int n1, input bit seq);
        logic [7:0] t0[$], t1[$];
        logic [7:0] w;
        bit p;
        for (int i = 0; i < n0 * TPI; i++) begin
            w = seq ? 8'(i % TPI) : 8'($urandom);
            t0.push_back(w); src0_q.push_back(w);
        end
        for (int i = 0; i < n1 * TPI; i++) begin
            w = 8'($urandom);
            t1.push_back(w); src1_q.push_back(w);
        end
        while (n0 > 0 || n1 > 0) begin
            p = (n0 > 0 && n1 > 0) ? !m_last : (n1 > 0);
            m_last = p;
            order.push_back(p);
            for (int b = 0; b < TPI; b++) exp_core.push_back(p ? t1.pop_front() : t0.pop_front());
            if (p) n1--; else n0--;
        end
    endtask

    task automatic tick();
        @(negedge i_aclk); #1;
    endtask

    task automatic drain(input string name, input int budget);
        int t = 0;
        while ((exp_core.size() > 0 || exp_m0.size() > 0 || exp_m1.size() > 0 || res_img < order.size()) && t < budget) begin
            tick(); t++;
        end
        if (t >= budget) bad({name, "_timeout"});
    endtask

    task automatic check_idle(input string name);
        chk(name, 32'({o_grant, o_core_tvalid, o_s0_tready, o_s1_tready, o_res_tready, o_m0_tvalid, o_m1_tvalid}), 32'd0);
    endtask

    // Sources: beat 0 of an image is always offered; later beats may be gapped
    initial forever begin
        @(posedge i_aclk); #1;
        if (s0_hs && src0_q.size() > 0) begin src0_q.delete(0); src_idx0 = (src_idx0 + 1) % TPI; end
        if (s1_hs && src1_q.size() > 0) begin src1_q.delete(0); src_idx1 = (src_idx1 + 1) % TPI; end
        i_s0_tvalid = src0_q.size() > 0 && (src_idx0 == 0 || !src_gap || $urandom_range(3) != 0);
        i_s1_tvalid = src1_q.size() > 0 && (src_idx1 == 0 || !src_gap || $urandom_range(3) != 0);
        i_s0_tdata  = src0_q.size() > 0 ? src0_q[0] : 8'h00;
        i_s1_tdata  = src1_q.size() > 0 ? src1_q[0] : 8'h00;
    end

    initial forever begin
        @(posedge i_aclk); #1;
        i_core_tready = cmode == 3 ? !i_core_tready : cmode == 2 ? 1'($urandom_range(1)) : 1'(cmode == 1);
        i_m0_tready   = m0mode == 2 ? 1'($urandom_range(1)) : 1'(m0mode == 1);
        i_m1_tready   = m1mode == 2 ? 1'($urandom_range(1)) : 1'(m1mode == 1);
    end

    // Stand-in core: OB result beats per completed input image, expected sink taken from the plan
    initial forever begin
        @(posedge i_aclk); #1;
        if (r_hs && res_pushed) begin
            res_pushed = 0;
            res_beat++;
            if (res_beat == OB) begin res_beat = 0; res_img++; end
        end
        if (!res_pushed && res_img < img_done && res_img < res_limit && res_img < order.size()) begin
            i_res_tdata = 16'($urandom);
            if (order[res_img]) exp_m1.push_back(i_res_tdata);
            else exp_m0.push_back(i_res_tdata);
            res_pushed = 1;
        end
        i_res_tvalid = res_pushed && (!res_gap || $urandom_range(3) != 0);
    end

    always @(negedge i_aclk) begin
        s0_hs = i_s0_tvalid && o_s0_tready;
        s1_hs = i_s1_tvalid && o_s1_tready;
        r_hs  = i_res_tvalid && o_res_tready;
        if (!i_areset) begin
            if (just_ended) chk("bubble", 32'(o_grant), 32'd0);
            just_ended = 0;
            if (o_grant != 2'b00 && prev_grant == 2'b00) begin
                rise_cyc = cyc; last_gap = cyc - end_cyc; last_pop_gap = cyc - pop_cyc;
            end
            prev_grant = o_grant;
            chk("rdy_gate", 32'({o_s1_tready, o_s0_tready} & ~o_grant), 32'd0);
            if (o_core_tvalid && i_core_tready) begin
                if (exp_core.size() == 0 || img_done >= order.size()) bad("core_unexpected_beat");
                else begin
                    chk("core_data", 32'(o_core_tdata), 32'(exp_core.pop_front()));
                    chk("grant", 32'(o_grant), order[img_done] ? 32'd2 : 32'd1);
                    in_beats++;
                    if (in_beats == TPI) begin
                        in_beats = 0; img_done++; end_cyc = cyc; last_len = cyc - rise_cyc + 1; just_ended = 1;
                    end
                end
            end
            if (o_m0_tvalid && exp_m0.size() == 0) bad("m0_unexpected_valid");
            else if (o_m0_tvalid && i_m0_tready) chk("m0_data", 32'(o_m0_tdata), 32'(exp_m0.pop_front()));
            if (o_m1_tvalid && exp_m1.size() == 0) bad("m1_unexpected_valid");
            else if (o_m1_tvalid && i_m1_tready) chk("m1_data", 32'(o_m1_tdata), 32'(exp_m1.pop_front()));
            if (r_hs) begin
                res_cnt++;
                if (res_cnt % OB == 0) pop_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        flush();
        repeat (3) @(posedge i_aclk);
        tick();
        check_idle("reset_outputs");
        i_areset = 1'b0;

        plan(1, 0, 1'b1);
        drain("t1", 2000);
        chk("t1_images", 32'(img_done), 32'd1);
        chk("t1_results", 32'(res_cnt), 32'd16);

        plan(1, 1, 1'b0);
        drain("t2", 2000);
        chk("t2_idle_gap", 32'(last_gap), 32'd2);
        chk("t2_results", 32'(res_cnt), 32'd48);

        cmode = 3;
        plan(1, 0, 1'b0);
        drain("t3", 2000);
        chk("t3_grant_len", 32'(last_len >= 63 && last_len <= 64), 32'd1);
        cmode = 1;

        base = img_done;
        res_limit = base;
        plan(5, 0, 1'b0);
        t = 0;
        while (img_done < base + 4 && t < 1000) begin tick(); t++; end
        repeat (20) tick();
        chk("t4_granted", 32'(img_done - base), 32'd4);
        chk("t4_fifth_waits", 32'(o_grant), 32'd0);
        res_limit = base + 1;
        t = 0;
        while (o_grant == 2'b00 && t < 500) begin tick(); t++; end
        chk("t4_grant_after_pop", 32'(last_pop_gap), 32'd2);
        res_limit = 1000;
        drain("t4", 4000);

        base = img_done;
        m1mode = 0;
        plan(0, 1, 1'b0);
        t = 0;
        while (img_done < base + 1 && t < 1000) begin tick(); t++; end
        repeat (20) begin
            tick();
            chk("t5_blocked", 32'({o_res_tready, o_m0_tvalid, o_m1_tvalid}), 32'd1);
        end
        m1mode = 1;
        drain("t5", 2000);

        plan(0, 1, 1'b0);
        t = 0;
        while (in_beats < 10 && t < 1000) begin tick(); t++; end
        i_areset = 1'b1;
        @(posedge i_aclk); #2;
        flush();
        tick();
        check_idle("t6_after_reset");
        tick();
        i_areset = 1'b0;
        plan(1, 0, 1'b0);
        drain("t6", 2000);
        chk("t6_results", 32'(res_cnt), 32'd16);

        src_gap = 1; res_gap = 1; cmode = 2; m0mode = 2; m1mode = 2;
        repeat (3) begin
            plan(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)), 1'b0);
            drain("random", 20000);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
